// File: rtl/mem_pkg.sv
// Package: mem_pkg
// Shared definitions for the home-node directory/data storage.
//   - default widths for the storage parameters
//   - home-state encodings (R, W, TR, TW)
//   - init/run FSM state type
//   - state-word layout {hst, dir} with pack/unpack helpers at default widths
package mem_pkg;

  // Default geometry: 128 lines of 16 bytes, 4-sharer directory.
  localparam int DEF_OFF_W  = 4;
  localparam int DEF_IDX_W  = 7;
  localparam int DEF_DIR_W  = 4;
  localparam int DEF_HST_W  = 2;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_ST_W   = DEF_HST_W + DEF_DIR_W;

  // Home-state encodings. R (00) is the post-sweep value of every entry.
  localparam logic [1:0] HST_R  = 2'b00;
  localparam logic [1:0] HST_W  = 2'b01;
  localparam logic [1:0] HST_TR = 2'b10;
  localparam logic [1:0] HST_TW = 2'b11;

  // Init sweep followed by normal operation.
  typedef enum logic {
    FSM_INIT = 1'b0,
    FSM_RUN  = 1'b1
  } fsm_e;

  // State word as stored in the state RAM: home state in the MSBs.
  typedef struct packed {
    logic [DEF_HST_W-1:0] hst;
    logic [DEF_DIR_W-1:0] dir;
  } st_word_t;

  function automatic logic [DEF_ST_W-1:0] pack_state(input logic [DEF_HST_W-1:0] hst,
                                                      input logic [DEF_DIR_W-1:0] dir);
    return {hst, dir};
  endfunction

  function automatic st_word_t unpack_state(input logic [DEF_ST_W-1:0] word);
    return st_word_t'(word);
  endfunction

endpackage

// File: rtl/sp_bram_wf.sv
// Module: sp_bram_wf
// Single-port RAM with registered read, write-first behaviour and a per-lane
// write mask. The line is split into WIDTH/GRAN lanes, each held in its own
// array so every lane maps cleanly onto block RAM with a byte/word enable.
// Ports:
//   clk    in   1       clock, rising edge
//   re     in   1       read enable; rdata updates on the next edge
//   we     in   1       write enable (qualified per lane by wmask)
//   wmask  in   NLANE   lane write enables
//   addr   in   AW      line index
//   wdata  in   WIDTH   write data
//   rdata  out  WIDTH   registered read data, holds when re=0
module sp_bram_wf #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 128,
  parameter int GRAN  = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int NLANE = WIDTH / GRAN
) (
  input  logic             clk,
  input  logic             re,
  input  logic             we,
  input  logic [NLANE-1:0] wmask,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
    logic [GRAN-1:0] mem [DEPTH];
    logic [GRAN-1:0] q_reg;
    logic            lane_we;

    assign lane_we = we & wmask[gi];

    // Write-first: a read colliding with a write to this lane returns the
    // new lane value; unmasked lanes return the stored value, which together
    // yields the merged line.
    always_ff @(posedge clk) begin
      if (lane_we) begin
        mem[addr] <= wdata[gi*GRAN +: GRAN];
      end
      if (re) begin
        q_reg <= lane_we ? wdata[gi*GRAN +: GRAN] : mem[addr];
      end
    end

    assign rdata[gi*GRAN +: GRAN] = q_reg;
  end

endmodule

// File: rtl/home_dir_data_ram.sv
// Module: home_dir_data_ram
// Home-node storage: a directory/state RAM and a line-data RAM sharing one
// index. After reset a sweep writes every state entry to R with an empty
// directory; requests are accepted only once the sweep has finished.
// Ports:
//   clk            in   1       clock, rising edge
//   rst_n          in   1       asynchronous reset, active low
//   ready_out      out  1       sweep done, requests accepted
//   addr_in        in   32      byte address, index = addr_in[OFF_W +: IDX_W]
//   state_re_in    in   1       state read request
//   state_we_in    in   1       state write request
//   state_in       in   ST_W    state write data {hst, dir}
//   data_re_in     in   1       data read request
//   data_we_in     in   1       data write request
//   data_wmask_in  in   NWORD   per-word write enables
//   data_in        in   DATA_W  data write data
//   state_out      out  ST_W    state read result (valid with state_vld_out)
//   state_vld_out  out  1       one-cycle pulse after an accepted state read
//   data_out       out  DATA_W  data read result (valid with data_vld_out)
//   data_vld_out   out  1       one-cycle pulse after an accepted data read
module home_dir_data_ram #(
  parameter int OFF_W  = mem_pkg::DEF_OFF_W,
  parameter int IDX_W  = mem_pkg::DEF_IDX_W,
  parameter int DIR_W  = mem_pkg::DEF_DIR_W,
  parameter int HST_W  = mem_pkg::DEF_HST_W,
  parameter int DATA_W = mem_pkg::DEF_DATA_W,
  parameter int WORD_W = mem_pkg::DEF_WORD_W,
  localparam int ST_W  = HST_W + DIR_W,
  localparam int NWORD = DATA_W / WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready_out,
  input  logic [31:0]       addr_in,
  input  logic              state_re_in,
  input  logic              state_we_in,
  input  logic [ST_W-1:0]   state_in,
  input  logic              data_re_in,
  input  logic              data_we_in,
  input  logic [NWORD-1:0]  data_wmask_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [ST_W-1:0]   state_out,
  output logic              state_vld_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_vld_out
);

  import mem_pkg::*;

  localparam int DEPTH = 2 ** IDX_W;

  // Value every state entry is swept to: home state R, no sharers.
  localparam logic [ST_W-1:0] INIT_WORD = {HST_W'(HST_R), {DIR_W{1'b0}}};

  // ---------------------------------------------------------------------
  // Init FSM and sweep counter
  // ---------------------------------------------------------------------
  fsm_e             fsm_reg, fsm_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;
  logic             ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg <= FSM_INIT;
      cnt_reg <= '0;
    end else begin
      fsm_reg <= fsm_next;
      cnt_reg <= cnt_next;
    end
  end

  always_comb begin
    fsm_next = fsm_reg;
    cnt_next = cnt_reg;
    case (fsm_reg)
      FSM_INIT: begin
        cnt_next = cnt_reg + 1'b1;
        // Last index is written this cycle; RUN starts on the next one.
        if (&cnt_reg) begin
          fsm_next = FSM_RUN;
        end
      end
      FSM_RUN: begin
        fsm_next = FSM_RUN;
      end
      default: begin
        fsm_next = FSM_INIT;
      end
    endcase
  end

  assign ready     = (fsm_reg == FSM_RUN);
  assign ready_out = ready;

  // ---------------------------------------------------------------------
  // Request gating and RAM port muxing
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  idx;
  logic              st_re, st_we;
  logic [IDX_W-1:0]  st_addr;
  logic [ST_W-1:0]   st_wdata;
  logic              dt_re, dt_we;

  // Upper address bits alias onto the same line; byte offset selects
  // nothing at line granularity.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_in[31:OFF_W+IDX_W], addr_in[OFF_W-1:0]};

  assign idx = addr_in[OFF_W +: IDX_W];

  always_comb begin
    st_re    = 1'b0;
    st_we    = 1'b0;
    st_addr  = idx;
    st_wdata = state_in;
    if (ready) begin
      st_re = state_re_in;
      st_we = state_we_in;
    end else begin
      // The sweep owns the state port until every entry is initialised.
      st_we    = 1'b1;
      st_addr  = cnt_reg;
      st_wdata = INIT_WORD;
    end
  end

  assign dt_re = ready & data_re_in;
  assign dt_we = ready & data_we_in;

  // ---------------------------------------------------------------------
  // RAMs
  // ---------------------------------------------------------------------
  logic [ST_W-1:0]   st_q;
  logic [DATA_W-1:0] dt_q;

  sp_bram_wf #(
    .DEPTH (DEPTH),
    .WIDTH (ST_W),
    .GRAN  (ST_W)
  ) u_state_ram (
    .clk   (clk),
    .re    (st_re),
    .we    (st_we),
    .wmask (1'b1),
    .addr  (st_addr),
    .wdata (st_wdata),
    .rdata (st_q)
  );

  sp_bram_wf #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W),
    .GRAN  (WORD_W)
  ) u_data_ram (
    .clk   (clk),
    .re    (dt_re),
    .we    (dt_we),
    .wmask (data_wmask_in),
    .addr  (idx),
    .wdata (data_in),
    .rdata (dt_q)
  );

  // ---------------------------------------------------------------------
  // Valid pulses and output hold
  // ---------------------------------------------------------------------
  // The RAM read registers cannot carry an async reset, so the visible
  // outputs select the RAM register only in the valid cycle and otherwise
  // show a resettable copy of the last delivered result.
  logic              state_vld_reg, data_vld_reg;
  logic [ST_W-1:0]   state_last_reg;
  logic [DATA_W-1:0] data_last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_vld_reg  <= 1'b0;
      data_vld_reg   <= 1'b0;
      state_last_reg <= '0;
      data_last_reg  <= '0;
    end else begin
      state_vld_reg <= st_re;
      data_vld_reg  <= dt_re;
      if (state_vld_reg) begin
        state_last_reg <= st_q;
      end
      if (data_vld_reg) begin
        data_last_reg <= dt_q;
      end
    end
  end

  assign state_vld_out = state_vld_reg;
  assign data_vld_out  = data_vld_reg;
  assign state_out     = state_vld_reg ? st_q : state_last_reg;
  assign data_out      = data_vld_reg  ? dt_q : data_last_reg;

endmodule
